// File: rtl/gate_checker_pkg.sv
// Shared definitions for the gate checker: FSM encoding, truth tables and vector order.
package gate_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    localparam logic [1:0] VEC_FIRST = 2'b00;
    localparam logic [1:0] VEC_LAST  = 2'b11;

    // Vectors are walked as a plain binary count of {A,B}.
    function automatic logic [1:0] next_vec(input logic [1:0] v);
        return v + 2'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single bit, asynchronously reset to 0.
module sync_2ff (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gate_checker.sv
// Stimulus-and-check engine for a 2-input gate: sweeps {A,B} and compares Y to EXPECT.
// Define GATE_CHECKER_SYNC_EN to pass Y through a 2-flop synchroniser (adds 2 hold cycles per vector).
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter logic [3:0] EXPECT = TT_AND,
    parameter int          SETTLE = 2,
    parameter int          N_PASS = 1,
    parameter int          ERR_W  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             Y,
    output logic             A,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [1:0]       FAIL_VEC
);

    logic y_cmp;

`ifdef GATE_CHECKER_SYNC_EN
    localparam int HOLD_LEN = SETTLE + 2;

    sync_2ff u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (Y),
        .q     (y_cmp)
    );
`else
    localparam int HOLD_LEN = SETTLE;

    assign y_cmp = Y;
`endif

    // HOLD lasts HOLD_LEN cycles, so the counter is loaded with HOLD_LEN-1 and runs down to 0.
    localparam int             HW        = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
    localparam int             PW        = (N_PASS > 1) ? $clog2(N_PASS) : 1;
    localparam logic [HW-1:0]  HOLD_LOAD = HW'((HOLD_LEN > 0) ? HOLD_LEN - 1 : 0);
    localparam logic [PW-1:0]  PASS_LAST = PW'(N_PASS - 1);

    state_t        state;
    state_t        state_next;
    logic [1:0]    vec;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] pass_cnt;
    logic          mismatch;
    logic          hold_done;
    logic          last_sample;

    assign mismatch    = (y_cmp != EXPECT[vec]);
    assign hold_done   = (hold_cnt == '0);
    assign last_sample = (vec == VEC_LAST) && (pass_cnt == PASS_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With no hold cycles each vector lives only in SAMPLE, so HOLD is skipped entirely.
    always_comb begin
        state_next = state;
        A          = 1'b0;
        B          = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next = (HOLD_LEN == 0) ? ST_SAMPLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                A    = vec[1];
                B    = vec[0];
                BUSY = 1'b1;
                if (hold_done) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                A    = vec[1];
                B    = vec[0];
                BUSY = 1'b1;
                if (last_sample) begin
                    state_next = ST_FINISH;
                end else begin
                    state_next = (HOLD_LEN == 0) ? ST_SAMPLE : ST_HOLD;
                end
            end
            ST_FINISH: begin
                DONE       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vec      <= VEC_FIRST;
            hold_cnt <= '0;
            pass_cnt <= '0;
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            PASS     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        vec      <= VEC_FIRST;
                        hold_cnt <= HOLD_LOAD;
                        pass_cnt <= '0;
                        ERR_CNT  <= '0;
                        FAIL_VEC <= '0;
                        PASS     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        FAIL_VEC <= vec;
                        if (ERR_CNT != '1) begin
                            ERR_CNT <= ERR_CNT + ERR_W'(1);
                        end
                    end
                    vec      <= next_vec(vec);
                    hold_cnt <= HOLD_LOAD;
                    if (vec == VEC_LAST) begin
                        pass_cnt <= pass_cnt + PW'(1);
                    end
                end
                ST_FINISH: begin
                    PASS <= (ERR_CNT == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
